mem_region_router: RTL and testbench

Registered, handshaked successor to the combinational OCM/cache address router. It sits between the core's memory stage and two targets: the non-cacheable OCM and the L1 data cache. Each request is decoded against parametrised region bounds, latched, and issued to one target; the block then waits a variable number of cycles for that target's acknowledge. Extra functions: unmapped-address error responses, a per-request timeout, and an OCM bus lock held across atomic read-modify-write pairs.

---
 rtl/mem_region_router_if.sv | 55 +++++
 rtl/mem_region_router.sv | 177 +++++++++++++++++
 tb/tb_mem_region_router.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_region_router_if.sv
// rtl/mem_region_router_if.sv - core and target buses of the memory region router
// slave = router view, master = core/target side.
interface mem_region_router_if #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32
);
  logic                 i_req;
  logic [ADDR_BITS-1:0] i_addr;
  logic [DATA_BITS-1:0] i_data;
  logic                 i_wr;
  logic                 i_rd;
  logic [3:0]           i_dm_write;
  logic                 i_is_atomic;
  logic                 o_stall;
  logic                 o_ack;
  logic [DATA_BITS-1:0] o_rdata;
  logic                 o_err;

  logic                 o_ocm_req;
  logic                 o_ocm_wr;
  logic                 o_ocm_rd;
  logic [ADDR_BITS-1:0] o_ocm_addr;
  logic [3:0]           o_ocm_dm_write;
  logic [DATA_BITS-1:0] o_ocm_data;
  logic                 o_ocm_lock;
  logic                 i_ocm_ack;
  logic [DATA_BITS-1:0] i_ocm_rdata;

  logic                 o_c_req;
  logic                 o_c_wr;
  logic                 o_c_rd;
  logic [ADDR_BITS-1:0] o_c_addr;
  logic [3:0]           o_c_dm_write;
  logic [DATA_BITS-1:0] o_c_data;
  logic                 i_c_ack;
  logic [DATA_BITS-1:0] i_c_rdata;

  modport slave (
    input  i_req, i_addr, i_data, i_wr, i_rd, i_dm_write, i_is_atomic,
    output o_stall, o_ack, o_rdata, o_err,
    output o_ocm_req, o_ocm_wr, o_ocm_rd, o_ocm_addr, o_ocm_dm_write, o_ocm_data, o_ocm_lock,
    input  i_ocm_ack, i_ocm_rdata,
    output o_c_req, o_c_wr, o_c_rd, o_c_addr, o_c_dm_write, o_c_data,
    input  i_c_ack, i_c_rdata
  );

  modport master (
    output i_req, i_addr, i_data, i_wr, i_rd, i_dm_write, i_is_atomic,
    input  o_stall, o_ack, o_rdata, o_err,
    input  o_ocm_req, o_ocm_wr, o_ocm_rd, o_ocm_addr, o_ocm_dm_write, o_ocm_data, o_ocm_lock,
    output i_ocm_ack, i_ocm_rdata,
    input  o_c_req, o_c_wr, o_c_rd, o_c_addr, o_c_dm_write, o_c_data,
    output i_c_ack, i_c_rdata
  );
endinterface

// File: rtl/mem_region_router.sv
// rtl/mem_region_router.sv - registered OCM/cache request router with error, timeout and atomic lock
// One request in flight; target outputs are flop-driven and gated by the per-target request flag.
module mem_region_router #(
  parameter int                   ADDR_BITS     = 32,
  parameter int                   DATA_BITS     = 32,
  parameter logic [ADDR_BITS-1:0] OCM_BASE      = 32'h0000_0000,
  parameter logic [ADDR_BITS-1:0] OCM_END       = 32'h0000_0FFF,
  parameter logic [ADDR_BITS-1:0] CACHE_BASE    = 32'h0000_1000,
  parameter logic [ADDR_BITS-1:0] CACHE_END     = 32'h0000_FFFF,
  parameter bit                   OCM_WORD_ADDR = 1'b1,
  parameter int unsigned          TIMEOUT       = 255
) (
  input logic                clk,
  input logic                rst,
  mem_region_router_if.slave bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE_OCM = 3'd1;
  localparam logic [2:0] S_ISSUE_C   = 3'd2;
  localparam logic [2:0] S_ERR       = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  localparam logic [ADDR_BITS-1:0] OCM_SPAN = OCM_END - OCM_BASE;
  localparam logic [ADDR_BITS-1:0] C_SPAN   = CACHE_END - CACHE_BASE;
  localparam logic [15:0]          TO_LAST  = 16'(TIMEOUT - 1);

  logic [2:0]           state;
  logic [15:0]          cnt;
  logic                 ocm_req_q;
  logic                 c_req_q;
  logic                 wr_q;
  logic                 lock_q;
  logic                 clr_lock_q;
  logic                 ack_q;
  logic                 err_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [DATA_BITS-1:0] data_q;
  logic [DATA_BITS-1:0] rdata_q;
  logic [3:0]           dm_q;

  logic                 new_req;
  logic                 in_ocm;
  logic                 in_c;
  logic [ADDR_BITS-1:0] ocm_off;
  logic [ADDR_BITS-1:0] c_off;
  logic [ADDR_BITS-1:0] ocm_tgt_addr;

  // Offset-and-span compares avoid constant-true checks when a base is zero.
  always_comb begin
    new_req      = bus.i_req & (bus.i_rd | bus.i_wr);
    ocm_off      = bus.i_addr - OCM_BASE;
    c_off        = bus.i_addr - CACHE_BASE;
    in_ocm       = (ocm_off <= OCM_SPAN);
    in_c         = (c_off <= C_SPAN);
    ocm_tgt_addr = OCM_WORD_ADDR ? (ocm_off >> 2) : bus.i_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      ocm_req_q  <= 1'b0;
      c_req_q    <= 1'b0;
      wr_q       <= 1'b0;
      lock_q     <= 1'b0;
      clr_lock_q <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      rdata_q    <= '0;
      dm_q       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (new_req) begin
            wr_q   <= bus.i_wr;
            dm_q   <= bus.i_dm_write;
            data_q <= bus.i_data;
            cnt    <= '0;
            if (in_ocm) begin
              addr_q    <= ocm_tgt_addr;
              ocm_req_q <= 1'b1;
              state     <= S_ISSUE_OCM;
              if (bus.i_is_atomic) lock_q <= 1'b1;
            end else if (in_c) begin
              addr_q  <= bus.i_addr;
              c_req_q <= 1'b1;
              state   <= S_ISSUE_C;
            end else begin
              addr_q <= bus.i_addr;
              state  <= S_ERR;
            end
          end
        end
        S_ISSUE_OCM: begin
          if (bus.i_ocm_ack) begin
            ocm_req_q  <= 1'b0;
            rdata_q    <= wr_q ? '0 : bus.i_ocm_rdata;
            err_q      <= 1'b0;
            ack_q      <= 1'b1;
            clr_lock_q <= wr_q;
            state      <= S_DONE;
          end else if (cnt == TO_LAST) begin
            ocm_req_q  <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b1;
            ack_q      <= 1'b1;
            clr_lock_q <= 1'b1;
            state      <= S_DONE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_ISSUE_C: begin
          // A completed cache access leaves any OCM lock untouched.
          if (bus.i_c_ack) begin
            c_req_q    <= 1'b0;
            rdata_q    <= wr_q ? '0 : bus.i_c_rdata;
            err_q      <= 1'b0;
            ack_q      <= 1'b1;
            clr_lock_q <= 1'b0;
            state      <= S_DONE;
          end else if (cnt == TO_LAST) begin
            c_req_q    <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b1;
            ack_q      <= 1'b1;
            clr_lock_q <= 1'b1;
            state      <= S_DONE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_ERR: begin
          rdata_q    <= '0;
          err_q      <= 1'b1;
          ack_q      <= 1'b1;
          clr_lock_q <= 1'b1;
          state      <= S_DONE;
        end
        S_DONE: begin
          ack_q      <= 1'b0;
          err_q      <= 1'b0;
          rdata_q    <= '0;
          clr_lock_q <= 1'b0;
          if (clr_lock_q) lock_q <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_ack   = ack_q;
  assign bus.o_err   = err_q;
  assign bus.o_rdata = rdata_q;
  assign bus.o_stall = ~rst & bus.i_req &
                       (((state != S_IDLE) & (state != S_DONE)) | ((state == S_IDLE) & new_req));

  assign bus.o_ocm_req      = ocm_req_q;
  assign bus.o_ocm_wr       = ocm_req_q & wr_q;
  assign bus.o_ocm_rd       = ocm_req_q & ~wr_q;
  assign bus.o_ocm_addr     = ocm_req_q ? addr_q : '0;
  assign bus.o_ocm_dm_write = ocm_req_q ? dm_q : 4'b0;
  assign bus.o_ocm_data     = ocm_req_q ? data_q : '0;
  assign bus.o_ocm_lock     = lock_q;

  assign bus.o_c_req      = c_req_q;
  assign bus.o_c_wr       = c_req_q & wr_q;
  assign bus.o_c_rd       = c_req_q & ~wr_q;
  assign bus.o_c_addr     = c_req_q ? addr_q : '0;
  assign bus.o_c_dm_write = c_req_q ? dm_q : 4'b0;
  assign bus.o_c_data     = c_req_q ? data_q : '0;

endmodule

// File: tb/tb_mem_region_router.sv
// tb/tb_mem_region_router.sv - directed bench for mem_region_router
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns later.
module tb_mem_region_router;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_region_router_if #(.ADDR_BITS(32), .DATA_BITS(32)) bus ();

  mem_region_router #(
    .ADDR_BITS(32), .DATA_BITS(32),
    .OCM_BASE(32'h0000_0000), .OCM_END(32'h0000_0FFF),
    .CACHE_BASE(32'h0000_1000), .CACHE_END(32'h0000_FFFF),
    .OCM_WORD_ADDR(1'b1), .TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic wr, input logic rd,
                       input logic atomic, input logic [3:0] dm, input logic [31:0] d);
    bus.i_req       = 1'b1;
    bus.i_addr      = a;
    bus.i_wr        = wr;
    bus.i_rd        = rd;
    bus.i_is_atomic = atomic;
    bus.i_dm_write  = dm;
    bus.i_data      = d;
  endtask

  task automatic release_core();
    bus.i_req       = 1'b0;
    bus.i_wr        = 1'b0;
    bus.i_rd        = 1'b0;
    bus.i_is_atomic = 1'b0;
  endtask

  initial begin
    bus.i_req = 0; bus.i_addr = 0; bus.i_data = 0; bus.i_wr = 0; bus.i_rd = 0;
    bus.i_dm_write = 0; bus.i_is_atomic = 0;
    bus.i_ocm_ack = 0; bus.i_ocm_rdata = 0; bus.i_c_ack = 0; bus.i_c_rdata = 0;

    // Reset: outputs low even with a request pending
    cyc();
    drive(32'h10, 1'b0, 1'b1, 1'b0, 4'hF, 32'h0);
    settle();
    chk("rst_stall", bus.o_stall, 0);
    chk("rst_ack", bus.o_ack, 0);
    chk("rst_ocm_req", bus.o_ocm_req, 0);
    chk("rst_c_req", bus.o_c_req, 0);
    chk("rst_lock", bus.o_ocm_lock, 0);
    release_core();
    cyc();
    rst = 1'b0;
    cyc();

    // OCM read at 0x10, ack in third request cycle
    drive(32'h0000_0010, 1'b0, 1'b1, 1'b0, 4'hF, 32'h0);
    settle();
    chk("t1_stall_c0", bus.o_stall, 1);
    cyc();
    chk("t1_ocm_req_c1", bus.o_ocm_req, 1);
    chk("t1_ocm_addr", bus.o_ocm_addr, 32'h4);
    chk("t1_ocm_rd", bus.o_ocm_rd, 1);
    chk("t1_ocm_wr", bus.o_ocm_wr, 0);
    chk("t1_c_req", bus.o_c_req, 0);
    chk("t1_stall_c1", bus.o_stall, 1);
    cyc();
    chk("t1_ocm_req_c2", bus.o_ocm_req, 1);
    cyc();
    chk("t1_ocm_req_c3", bus.o_ocm_req, 1);
    bus.i_ocm_ack = 1'b1; bus.i_ocm_rdata = 32'hDEAD_BEEF;
    cyc();
    bus.i_ocm_ack = 1'b0;
    settle();
    chk("t1_ocm_req_done", bus.o_ocm_req, 0);
    chk("t1_ack", bus.o_ack, 1);
    chk("t1_rdata", bus.o_rdata, 32'hDEAD_BEEF);
    chk("t1_err", bus.o_err, 0);
    chk("t1_stall_done", bus.o_stall, 0);
    release_core();
    cyc();
    chk("t1_ack_pulse", bus.o_ack, 0);

    // Cache write at 0x2000, immediate ack; read data must be ignored
    drive(32'h0000_2000, 1'b1, 1'b0, 1'b0, 4'b0011, 32'h1234_5678);
    cyc();
    chk("t2_c_req", bus.o_c_req, 1);
    chk("t2_c_wr", bus.o_c_wr, 1);
    chk("t2_c_rd", bus.o_c_rd, 0);
    chk("t2_c_addr", bus.o_c_addr, 32'h2000);
    chk("t2_c_dm", bus.o_c_dm_write, 32'h3);
    chk("t2_c_data", bus.o_c_data, 32'h1234_5678);
    chk("t2_ocm_req", bus.o_ocm_req, 0);
    chk("t2_ocm_addr", bus.o_ocm_addr, 0);
    bus.i_c_ack = 1'b1; bus.i_c_rdata = 32'hAAAA_5555;
    cyc();
    bus.i_c_ack = 1'b0;
    chk("t2_ack", bus.o_ack, 1);
    chk("t2_rdata", bus.o_rdata, 0);
    chk("t2_err", bus.o_err, 0);
    chk("t2_c_req_done", bus.o_c_req, 0);
    release_core();
    cyc();

    // Unmapped read at 0x1_0000
    drive(32'h0001_0000, 1'b0, 1'b1, 1'b0, 4'hF, 32'h0);
    cyc();
    chk("t3_ocm_req", bus.o_ocm_req, 0);
    chk("t3_c_req", bus.o_c_req, 0);
    chk("t3_ack_c1", bus.o_ack, 0);
    chk("t3_stall", bus.o_stall, 1);
    cyc();
    chk("t3_ack", bus.o_ack, 1);
    chk("t3_err", bus.o_err, 1);
    chk("t3_rdata", bus.o_rdata, 0);
    release_core();
    cyc();

    // Cache read timeout (TIMEOUT=4) with a stray OCM ack in between
    drive(32'h0000_3000, 1'b0, 1'b1, 1'b0, 4'hF, 32'h0);
    cyc();
    chk("t4_c_req_c1", bus.o_c_req, 1);
    cyc();
    bus.i_ocm_ack = 1'b1; bus.i_ocm_rdata = 32'h1111_1111;
    cyc();
    bus.i_ocm_ack = 1'b0;
    chk("t4_stray_ack", bus.o_ack, 0);
    chk("t4_c_req_c3", bus.o_c_req, 1);
    cyc();
    chk("t4_c_req_c4", bus.o_c_req, 1);
    cyc();
    chk("t4_c_req_drop", bus.o_c_req, 0);
    chk("t4_ack", bus.o_ack, 1);
    chk("t4_err", bus.o_err, 1);
    release_core();
    cyc();

    // Atomic read of OCM 0x100, cache read while locked, then write (rd&wr both high)
    drive(32'h0000_0100, 1'b0, 1'b1, 1'b1, 4'hF, 32'h0);
    cyc();
    chk("t5_lock_issue", bus.o_ocm_lock, 1);
    chk("t5_ocm_addr", bus.o_ocm_addr, 32'h40);
    bus.i_ocm_ack = 1'b1; bus.i_ocm_rdata = 32'h0000_00AB;
    cyc();
    bus.i_ocm_ack = 1'b0;
    chk("t5_rd_ack", bus.o_ack, 1);
    chk("t5_rd_rdata", bus.o_rdata, 32'hAB);
    release_core();
    cyc();
    chk("t5_lock_idle", bus.o_ocm_lock, 1);
    drive(32'h0000_4000, 1'b0, 1'b1, 1'b1, 4'hF, 32'h0);
    cyc();
    bus.i_c_ack = 1'b1; bus.i_c_rdata = 32'h0000_0077;
    cyc();
    bus.i_c_ack = 1'b0;
    chk("t5_c_rdata", bus.o_rdata, 32'h77);
    release_core();
    cyc();
    chk("t5_lock_after_c", bus.o_ocm_lock, 1);
    drive(32'h0000_0100, 1'b1, 1'b1, 1'b0, 4'hF, 32'hCAFE_0001);
    cyc();
    chk("t5_wr_wr", bus.o_ocm_wr, 1);
    chk("t5_wr_rd", bus.o_ocm_rd, 0);
    chk("t5_wr_lock", bus.o_ocm_lock, 1);
    bus.i_ocm_ack = 1'b1;
    cyc();
    bus.i_ocm_ack = 1'b0;
    chk("t5_wr_ack", bus.o_ack, 1);
    chk("t5_lock_done", bus.o_ocm_lock, 1);
    release_core();
    cyc();
    chk("t5_lock_clear", bus.o_ocm_lock, 0);

    // Reset mid-transaction with lock set
    drive(32'h0000_0020, 1'b0, 1'b1, 1'b1, 4'hF, 32'h0);
    cyc();
    chk("t6_lock_set", bus.o_ocm_lock, 1);
    cyc();
    rst = 1'b1;
    settle();
    chk("t6_rst_ocm_req", bus.o_ocm_req, 0);
    chk("t6_rst_lock", bus.o_ocm_lock, 0);
    chk("t6_rst_stall", bus.o_stall, 0);
    chk("t6_rst_addr", bus.o_ocm_addr, 0);
    release_core();
    cyc();
    rst = 1'b0;
    cyc();
    chk("t6_no_ack", bus.o_ack, 0);
    drive(32'h0000_0008, 1'b1, 1'b0, 1'b0, 4'b1000, 32'h5A5A_5A5A);
    cyc();
    chk("t6_new_req", bus.o_ocm_req, 1);
    chk("t6_new_addr", bus.o_ocm_addr, 32'h2);
    chk("t6_new_dm", bus.o_ocm_dm_write, 32'h8);
    chk("t6_new_lock", bus.o_ocm_lock, 0);
    bus.i_ocm_ack = 1'b1;
    cyc();
    bus.i_ocm_ack = 1'b0;
    chk("t6_new_ack", bus.o_ack, 1);
    chk("t6_new_err", bus.o_err, 0);
    release_core();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
